// File: rtl/encoder_rr_pkg.sv
// Shared constants and helpers for the request encoders and arbiters.
// Includes the clog2 sizing function and the priority-mode encodings.
package encoder_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder_pri.sv
// Combinational find-first-set starting at start_i, wrapping from N-1 to 0.
// Zero latency; no flow control, purely combinational.
module encoder_pri
  import encoder_rr_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  // Shifting the doubled vector gives a rotation, so bit k of rot is vec_i[(start_i+k) mod N].
  always_comb begin
    rot     = N'({vec_i, vec_i} >> start_i);
    found_o = |rot;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = W'(k);
    end
    idx_o = start_i + off;
  end

endmodule

// File: rtl/encoder_rr.sv
// Registered request encoder: pending pulses are granted one index per cycle, fixed or round-robin.
// Pulse-to-grant is 2 edges; a grant is held without preemption while ready is low.
module encoder_rr
  import encoder_rr_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         mode,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [N-1:0] pending
);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         load;
  logic [N-1:0] acc_mask;
  logic [N-1:0] src;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] idx;

  assign accept   = valid_q & ready;
  assign load     = ~valid_q | accept;
  assign acc_mask = accept ? ({{(N-1){1'b0}}, 1'b1} << dout_q) : '0;
  // din is kept out of the search so a request is never granted in its arrival cycle.
  assign src      = pending_q & ~acc_mask;
  assign start    = (mode == MODE_RR) ? ptr_q : '0;

  encoder_pri #(.N(N)) u_pri (
    .vec_i   (src),
    .start_i (start),
    .found_o (found),
    .idx_o   (idx)
  );

  always_comb begin
    pending_d = src | din;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ptr_d     = accept ? dout_q + W'(1) : ptr_q;
    if (load) begin
      valid_d = found;
      if (found) dout_d = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_encoder_rr.sv
// Directed bench for encoder_rr: N=8 vector table plus reset and N=16 sequences.
module tb_encoder_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        mode = 1'b0;
  logic        ready = 1'b0;
  logic [2:0]  dout;
  logic        valid;
  logic [7:0]  pending;

  logic [15:0] din16 = '0;
  logic        mode16 = 1'b0;
  logic        ready16 = 1'b0;
  logic [3:0]  dout16;
  logic        valid16;
  logic [15:0] pending16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encoder_rr #(.N(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .mode    (mode),
    .ready   (ready),
    .dout    (dout),
    .valid   (valid),
    .pending (pending)
  );

  encoder_rr #(.N(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .din     (din16),
    .mode    (mode16),
    .ready   (ready16),
    .dout    (dout16),
    .valid   (valid16),
    .pending (pending16)
  );

  typedef struct {
    logic [7:0] din;
    logic       mode;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_dout;
    logic [7:0] exp_pending;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step16(input string name, input logic [15:0] d, input logic m, input logic r,
                        input logic ev, input logic [3:0] ed, input logic [15:0] ep);
    din16   = d;
    mode16  = m;
    ready16 = r;
    tick();
    chk({name, ".valid"},   32'(valid16),   32'(ev));
    chk({name, ".dout"},    32'(dout16),    32'(ed));
    chk({name, ".pending"}, 32'(pending16), 32'(ep));
  endtask

  initial begin
    // din, mode, ready, exp valid, exp dout, exp pending
    tbl[0]  = '{8'hA0, 1'b0, 1'b1, 1'b0, 3'd0, 8'hA0};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'hA0};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00};
    tbl[4]  = '{8'h05, 1'b1, 1'b1, 1'b0, 3'd7, 8'h05};
    tbl[5]  = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h05};
    tbl[6]  = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04};
    tbl[7]  = '{8'h42, 1'b1, 1'b1, 1'b0, 3'd2, 8'h42};
    tbl[8]  = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd6, 8'h42};
    tbl[9]  = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02};
    tbl[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00};
    tbl[11] = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd1, 8'h08};
    tbl[12] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08};
    tbl[13] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd3, 8'h09};
    tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h09};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h09};
    tbl[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h09};
    tbl[17] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h09};
    tbl[18] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01};
    tbl[19] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[20] = '{8'h04, 1'b0, 1'b1, 1'b0, 3'd0, 8'h04};
    tbl[21] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04};
    tbl[22] = '{8'h04, 1'b0, 1'b1, 1'b0, 3'd2, 8'h04};
    tbl[23] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04};
    tbl[24] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};

    // Reset, then build up live state and drop reset in mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    chk("por.valid",   32'(valid),   32'd0);
    chk("por.pending", 32'(pending), 32'd0);
    rst = 1'b0;
    din = 8'h80;
    tick();
    din = 8'hFF;
    tick();
    chk("pre_rst.valid",   32'(valid),   32'd1);
    chk("pre_rst.dout",    32'(dout),    32'd7);
    chk("pre_rst.pending", 32'(pending), 32'hFF);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.valid",   32'(valid),   32'd0);
    chk("async_rst.dout",    32'(dout),    32'd0);
    chk("async_rst.pending", 32'(pending), 32'd0);
    din = 8'h00;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst%0d.valid", i),   32'(valid),   32'd0);
      chk($sformatf("post_rst%0d.pending", i), 32'(pending), 32'd0);
    end

    for (int i = 0; i < 25; i++) begin
      din   = tbl[i].din;
      mode  = tbl[i].mode;
      ready = tbl[i].ready;
      tick();
      chk($sformatf("row%0d.valid", i),   32'(valid),   32'(tbl[i].exp_valid));
      chk($sformatf("row%0d.dout", i),    32'(dout),    32'(tbl[i].exp_dout));
      chk($sformatf("row%0d.pending", i), 32'(pending), 32'(tbl[i].exp_pending));
    end
    din = 8'h00;

    // N=16: top bit in fixed mode, then steer ptr to 15 and check the wrap 15 -> 0.
    step16("n16_a", 16'h8000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h8000);
    step16("n16_b", 16'h0000, 1'b0, 1'b1, 1'b1, 4'd15, 16'h8000);
    step16("n16_c", 16'h0000, 1'b0, 1'b1, 1'b0, 4'd15, 16'h0000);
    step16("n16_d", 16'h4000, 1'b1, 1'b1, 1'b0, 4'd15, 16'h4000);
    step16("n16_e", 16'h0000, 1'b1, 1'b1, 1'b1, 4'd14, 16'h4000);
    step16("n16_f", 16'h0000, 1'b1, 1'b1, 1'b0, 4'd14, 16'h0000);
    step16("n16_g", 16'h8001, 1'b1, 1'b1, 1'b0, 4'd14, 16'h8001);
    step16("n16_h", 16'h0000, 1'b1, 1'b1, 1'b1, 4'd15, 16'h8001);
    step16("n16_i", 16'h0000, 1'b1, 1'b1, 1'b1, 4'd0,  16'h0001);
    step16("n16_j", 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_rr.md
Name: encoder_rr

Overview:
Parametrised, registered successor to the combinational 8-to-3 priority encoder. Incoming one-cycle request pulses are accumulated in a pending register. The block emits one index at a time on a valid/ready handshake, using either fixed LSB-first priority or rotating round-robin priority. Typical use is as a request arbiter or interrupt-index generator in front of shared logic.

Parameters:
N, 8, number of request lines; must be a power of 2 and at least 2.
W, derived localparam equal to clog2(N) (3 when N=8), width of the index output. Not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
din  input  N  request pulses; bit i high for one or more cycles sets pending[i].
mode  input  1  0 = fixed priority (bit 0 highest); 1 = round-robin.
ready  input  1  consumer accepts dout when valid && ready at a rising edge.
dout  output  W  index of the granted request, registered.
valid  output  1  dout holds a live grant.
pending  output  N  current pending-request register, for debug/status.

Behaviour:
- Reset (async, rst=1): pending=0, dout=0, valid=0, ptr=0. Outputs take these values immediately, not at the next edge.
- ptr is an internal W-bit round-robin start pointer.
- accept = valid && ready.
- acc_mask = one-hot(dout) when accept, else 0.
- Pending update at every edge: pending <= (pending & ~acc_mask) | din. If a bit is set and cleared in the same cycle, the set wins.
- Search source: src = pending & ~acc_mask. din is not included in src, so a request is never granted in the same cycle it arrives.
- Grant load happens when !valid || accept:
  - If src != 0: valid <= 1 and dout <= first set bit of src.
    - mode=0: search starts at bit 0 and moves upward.
    - mode=1: search starts at bit ptr, moves upward, and wraps from N-1 to 0.
  - If src == 0: valid <= 0 and dout holds its last value.
- Hold: while valid && !ready, dout and valid are frozen. There is no preemption, even if a higher-priority request arrives. The held bit stays set in pending.
- Pointer: on accept, ptr <= (dout+1) mod N in both modes, so state is consistent when mode flips. In mode 0 the pointer is ignored.
- Mode change takes effect at the next grant load only; a grant already held is not changed.
- Latency: din pulse at edge t sets pending at t; with an idle output, valid=1 after edge t+1 (2 cycles from pulse to grant).
- Throughput: one grant per cycle with ready held high.
- Multiple pulses on the same bit before it is granted collapse into a single grant (no counting).
- Reset asserted mid-operation discards all pending requests and any held grant.
- X on din or mode is never propagated into the search: no casex/default-x coding is used. A zero source yields valid=0, not dout=x.

Decomposition:
- Shared header: clog2 constant function and the MODE_FIXED=0 / MODE_RR=1 constants. These are reused by later encoders/arbiters.
- One natural sub-module: encoder_pri.
  - Purely combinational, parametrised N.
  - Inputs: vector and start index.
  - Outputs: found flag and W-bit index.
  - Implementation: double-width rotate-and-mask search.
- encoder_rr owns the registers (pending, dout, valid, ptr) and the handshake.

Test Plan:
1. Reset: drive din=8'hFF, then assert rst mid-cycle. Required: valid=0, pending=0, dout=0 immediately. After release with din=0, valid stays 0.
2. Fixed mode, ready=1: pulse din=8'b1010_0000 for one cycle. Required: valid=1 with dout=5 two edges later, dout=7 on the next cycle, then valid=0 and pending=0.
3. Round-robin: pending 8'b0000_0101, ready=1. Required sequence: dout=0 (ptr becomes 1), then dout=2 (ptr becomes 3). Then pulse din bit 1 and bit 6. Required: dout=6 before dout=1 (wrap-around).
4. Backpressure: ready=0 with grant dout=3 held; pulse din bit 0. Required: dout stays 3 and valid stays 1 for 5 cycles. After ready=1, the next grant is 0 (mode 0).
5. Simultaneous set/clear: grant dout=2 accepted in the same cycle as din bit 2 is pulsed. Required: pending[2] stays 1 and bit 2 is granted again later.
6. N=16 instance: pulse din=16'h8000. Required: dout=4'hF with valid=1. Then with N=16 in mode 1, pending 16'h8001 and ptr=15. Required: dout=15, then dout=0.
